// File: rtl/fifo_sync_param_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the parametrised synchronous FIFO family.
//   - FIFO_MODE_STD / FIFO_MODE_FWFT : values for the FWFT parameter
//   - clog2()                        : address width helper usable in
//                                      parameter / localparam expressions
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Smallest n with (1 << n) >= value. Written as a bounded loop so it stays
  // a legal constant function for every tool.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// -----------------------------------------------------------------------------
// fifo_sync_param_if
//   Bundles the producer/consumer side of fifo_sync_param.
//   Parameters : WIDTH (data bits), DEPTH (entries, sets count width)
//   master     : drives flush, wr_en, data_in, rd_en, clr_err;
//                observes data_out, rd_valid, status flags and count
//   slave      : the FIFO itself (mirror of master)
// -----------------------------------------------------------------------------
interface fifo_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) ();
  import fifo_pkg::*;

  localparam int AW = clog2(DEPTH);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, data_in, rd_en, clr_err,
    input  data_out, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en, clr_err,
    output data_out, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_sync_ram.sv
// -----------------------------------------------------------------------------
// fifo_sync_ram
//   DEPTH x WIDTH storage for fifo_sync_param: one write port, one read port.
//   ASYNC_READ = 0 : registered read (block-RAM style), output register is
//                    cleared by rst and updated only when rd_en is high.
//   ASYNC_READ = 1 : combinational read of rd_addr (used for FWFT, where the
//                    head word must be visible without a read request).
//   Ports: clk, rst (async, active-low), wr_en/wr_addr/wr_data,
//          rd_en/rd_addr, rd_data.
//   The storage array itself is never reset.
// -----------------------------------------------------------------------------
module fifo_sync_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter bit ASYNC_READ = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    if (ASYNC_READ) begin : g_async_read
      // Read enable and reset have no role when the read is combinational.
      logic unused_async;
      assign unused_async = rd_en ^ rst;
      assign rd_data      = mem[rd_addr];
    end else begin : g_sync_read
      logic [WIDTH-1:0] rd_data_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data_reg <= '0;
        end else if (rd_en) begin
          rd_data_reg <= mem[rd_addr];
        end
      end
      assign rd_data = rd_data_reg;
    end
  endgenerate

endmodule

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//   Parametrised single-clock FIFO with standard or first-word-fall-through
//   read mode, fill count, almost-full/almost-empty thresholds, sticky
//   overflow/underflow and synchronous flush.
//   Parameters: WIDTH, DEPTH (power of two >= 2), AF_THRESH, AE_THRESH, FWFT
//   Ports     : clk, rst (async, active-low), bus (fifo_sync_param_if.slave)
//               bus inputs : flush, wr_en, data_in, rd_en, clr_err
//               bus outputs: data_out, rd_valid, empty, full, almost_empty,
//                            almost_full, count, overflow, underflow
//   All status outputs are registered and move on the same edge as the
//   pointers.
// -----------------------------------------------------------------------------
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FIFO_MODE_STD
) (
  input  logic             clk,
  input  logic             rst,
  fifo_sync_param_if.slave bus
);

  localparam int          AW     = clog2(DEPTH);
  localparam logic [AW:0] AF_LIM = (AW + 1)'(AF_THRESH);
  localparam logic [AW:0] AE_LIM = (AW + 1)'(AE_THRESH);
  localparam bit          IS_FWFT = (FWFT == FIFO_MODE_FWFT);

  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic             empty_reg, empty_next;
  logic             full_reg, full_next;
  logic             almost_empty_reg, almost_empty_next;
  logic             almost_full_reg, almost_full_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             rd_valid_reg, rd_valid_next;

  logic             rd_accept;
  logic             wr_accept;
  logic             overflow_event;
  logic             underflow_event;
  logic [WIDTH-1:0] ram_rd_data;

  always_comb begin
    // Flush overrides both ports, so neither side moves a pointer or
    // raises an error in a flush cycle.
    rd_accept       = bus.rd_en & ~empty_reg & ~bus.flush;
    // A full FIFO can still take a write when the same cycle frees a slot.
    wr_accept       = bus.wr_en & (~full_reg | rd_accept) & ~bus.flush;
    overflow_event  = bus.wr_en & full_reg & ~rd_accept & ~bus.flush;
    underflow_event = bus.rd_en & empty_reg & ~bus.flush;

    wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, wr_accept};
    rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, rd_accept};
    count_next  = count_reg + {{AW{1'b0}}, wr_accept} - {{AW{1'b0}}, rd_accept};

    if (bus.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end

    // Extra pointer MSB distinguishes full (one lap apart) from empty.
    empty_next        = (wr_ptr_next == rd_ptr_next);
    full_next         = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                        (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    almost_empty_next = (count_next <= AE_LIM);
    almost_full_next  = (count_next >= AF_LIM);

    // A fresh error in the clearing cycle keeps the flag set.
    overflow_next  = (overflow_reg & ~bus.clr_err) | overflow_event;
    underflow_next = (underflow_reg & ~bus.clr_err) | underflow_event;

    // FWFT: valid tracks the registered empty flag. Standard: one-cycle
    // pulse following each accepted read.
    rd_valid_next = IS_FWFT ? ~empty_next : rd_accept;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_empty_reg <= 1'b1;
      almost_full_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
      rd_valid_reg     <= 1'b0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      empty_reg        <= empty_next;
      full_reg         <= full_next;
      almost_empty_reg <= almost_empty_next;
      almost_full_reg  <= almost_full_next;
      overflow_reg     <= overflow_next;
      underflow_reg    <= underflow_next;
      rd_valid_reg     <= rd_valid_next;
    end
  end

  fifo_sync_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .ASYNC_READ (IS_FWFT)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_data (bus.data_in),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (ram_rd_data)
  );

  generate
    if (IS_FWFT) begin : g_fwft_out
      // Head word is shown only while something is stored, so the output
      // is zero out of reset and never exposes stale storage.
      assign bus.data_out = empty_reg ? '0 : ram_rd_data;
    end else begin : g_std_out
      assign bus.data_out = ram_rd_data;
    end
  endgenerate

  assign bus.rd_valid     = rd_valid_reg;
  assign bus.empty        = empty_reg;
  assign bus.full         = full_reg;
  assign bus.almost_empty = almost_empty_reg;
  assign bus.almost_full  = almost_full_reg;
  assign bus.count        = count_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
//   Directed bench for fifo_sync_param: one standard-mode instance and one
//   FWFT instance (WIDTH=8, DEPTH=16, AF=14, AE=2). Inputs change 1 ns after
//   the rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) s_if ();
  fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) f_if ();

  fifo_sync_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(FIFO_MODE_STD)
  ) dut_std (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  fifo_sync_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(FIFO_MODE_FWFT)
  ) dut_fwft (
    .clk (clk),
    .rst (rst),
    .bus (f_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    s_if.flush = 1'b0; s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.clr_err = 1'b0; s_if.data_in = '0;
    f_if.flush = 1'b0; f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.clr_err = 1'b0; f_if.data_in = '0;
  endtask

  // Fill the standard instance with 16 words, first value base+1.
  task automatic fill_std(input int base);
    for (int i = 0; i < 16; i++) begin
      s_if.wr_en = 1'b1; s_if.data_in = 8'(base + i + 1);
      tick();
    end
    s_if.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b0;
    #12;
    $display("reset: power-on state");
    checks++; if (s_if.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", s_if.empty); end
    checks++; if (s_if.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", s_if.full); end
    checks++; if (s_if.count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", s_if.count); end
    checks++; if (s_if.data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", s_if.data_out); end
    checks++; if (s_if.almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae: got %b want 1", s_if.almost_empty); end
    checks++; if (s_if.almost_full !== 1'b0) begin errors++; $display("FAIL rst_af: got %b want 0", s_if.almost_full); end
    checks++; if (s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin errors++; $display("FAIL rst_err: got ovf=%b udf=%b want 0 0", s_if.overflow, s_if.underflow); end
    checks++; if (s_if.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", s_if.rd_valid); end
    checks++; if (f_if.empty !== 1'b1 || f_if.data_out !== 8'h00 || f_if.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_fwft: got empty=%b data=%h valid=%b want 1 00 0", f_if.empty, f_if.data_out, f_if.rd_valid); end
    @(negedge clk);
    rst = 1'b1;

    // Mid-stream: three writes, one read, then reset while a read is pending.
    for (int i = 0; i < 3; i++) begin
      s_if.wr_en = 1'b1; s_if.data_in = 8'((i + 1) * 17);
      tick();
    end
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b1;
    tick();
    checks++; if (s_if.data_out !== 8'h11) begin errors++; $display("FAIL mid_data: got %h want 11", s_if.data_out); end
    checks++; if (s_if.count !== 5'd2) begin errors++; $display("FAIL mid_count: got %0d want 2", s_if.count); end
    #2;
    rst = 1'b0;
    #1;
    $display("reset: asserted mid-stream");
    checks++; if (s_if.empty !== 1'b1) begin errors++; $display("FAIL async_empty: got %b want 1", s_if.empty); end
    checks++; if (s_if.full !== 1'b0) begin errors++; $display("FAIL async_full: got %b want 0", s_if.full); end
    checks++; if (s_if.count !== 5'd0) begin errors++; $display("FAIL async_count: got %0d want 0", s_if.count); end
    checks++; if (s_if.data_out !== 8'h00) begin errors++; $display("FAIL async_data: got %h want 00", s_if.data_out); end
    tick();
    checks++; if (s_if.data_out !== 8'h00 || s_if.rd_valid !== 1'b0) begin errors++; $display("FAIL inflight_lost: got data=%h valid=%b want 00 0", s_if.data_out, s_if.rd_valid); end
    s_if.rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic exp_af, exp_ae, exp_full;
    for (int i = 0; i < 16; i++) begin
      s_if.wr_en = 1'b1; s_if.data_in = 8'(i + 1);
      tick();
      exp_af = ((i + 1) >= 14); exp_ae = ((i + 1) <= 2); exp_full = (i == 15);
      $display("fill: wr %h count=%0d", 8'(i + 1), s_if.count);
      checks++; if (s_if.count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d want %0d", s_if.count, i + 1); end
      checks++; if (s_if.almost_full !== exp_af) begin errors++; $display("FAIL fill_af: got %b want %b at count %0d", s_if.almost_full, exp_af, i + 1); end
      checks++; if (s_if.almost_empty !== exp_ae) begin errors++; $display("FAIL fill_ae: got %b want %b at count %0d", s_if.almost_empty, exp_ae, i + 1); end
      checks++; if (s_if.full !== exp_full) begin errors++; $display("FAIL fill_full: got %b want %b at count %0d", s_if.full, exp_full, i + 1); end
    end
    s_if.wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_if.rd_en = 1'b1;
      tick();
      $display("drain: rd %h valid=%b", s_if.data_out, s_if.rd_valid);
      checks++; if (s_if.rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b want 1", s_if.rd_valid); end
      checks++; if (s_if.data_out !== 8'(i + 1)) begin errors++; $display("FAIL drain_data: got %h want %h", s_if.data_out, 8'(i + 1)); end
    end
    s_if.rd_en = 1'b0;
    checks++; if (s_if.empty !== 1'b1 || s_if.count !== 5'd0) begin errors++; $display("FAIL drain_empty: got empty=%b count=%0d want 1 0", s_if.empty, s_if.count); end
    tick();
    checks++; if (s_if.rd_valid !== 1'b0 || s_if.data_out !== 8'h10) begin errors++; $display("FAIL drain_hold: got valid=%b data=%h want 0 10", s_if.rd_valid, s_if.data_out); end
  endtask

  task automatic test_overflow();
    fill_std(8'h3F);
    s_if.wr_en = 1'b1; s_if.data_in = 8'hAA;
    tick();
    s_if.wr_en = 1'b0;
    $display("overflow: wr aa while full");
    checks++; if (s_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", s_if.overflow); end
    checks++; if (s_if.count !== 5'd16 || s_if.full !== 1'b1) begin errors++; $display("FAIL ovf_count: got count=%0d full=%b want 16 1", s_if.count, s_if.full); end
    s_if.clr_err = 1'b1;
    tick();
    s_if.clr_err = 1'b0;
    checks++; if (s_if.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", s_if.overflow); end
    for (int i = 0; i < 16; i++) begin
      s_if.rd_en = 1'b1;
      tick();
      $display("overflow drain: rd %h", s_if.data_out);
      checks++; if (s_if.data_out !== 8'(8'h40 + i)) begin errors++; $display("FAIL ovf_drain: got %h want %h", s_if.data_out, 8'(8'h40 + i)); end
    end
    s_if.rd_en = 1'b0;
    checks++; if (s_if.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", s_if.empty); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_data;
    fill_std(8'h20);
    s_if.wr_en = 1'b1; s_if.rd_en = 1'b1; s_if.data_in = 8'h55;
    tick();
    s_if.wr_en = 1'b0;
    $display("simul full: wr 55 + rd -> %h count=%0d", s_if.data_out, s_if.count);
    checks++; if (s_if.count !== 5'd16 || s_if.full !== 1'b1) begin errors++; $display("FAIL sim_full_count: got count=%0d full=%b want 16 1", s_if.count, s_if.full); end
    checks++; if (s_if.data_out !== 8'h21 || s_if.overflow !== 1'b0) begin errors++; $display("FAIL sim_full_rd: got data=%h ovf=%b want 21 0", s_if.data_out, s_if.overflow); end
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_data = (i < 15) ? 8'(8'h22 + i) : 8'h55;
      checks++; if (s_if.data_out !== exp_data) begin errors++; $display("FAIL sim_drain: got %h want %h", s_if.data_out, exp_data); end
    end
    s_if.rd_en = 1'b0;
    checks++; if (s_if.empty !== 1'b1) begin errors++; $display("FAIL sim_drain_empty: got %b want 1", s_if.empty); end

    s_if.wr_en = 1'b1; s_if.rd_en = 1'b1; s_if.data_in = 8'h66;
    tick();
    s_if.wr_en = 1'b0;
    $display("simul empty: wr 66 + rd count=%0d udf=%b", s_if.count, s_if.underflow);
    checks++; if (s_if.count !== 5'd1 || s_if.empty !== 1'b0) begin errors++; $display("FAIL sim_empty_count: got count=%0d empty=%b want 1 0", s_if.count, s_if.empty); end
    checks++; if (s_if.underflow !== 1'b1 || s_if.rd_valid !== 1'b0) begin errors++; $display("FAIL sim_empty_udf: got udf=%b valid=%b want 1 0", s_if.underflow, s_if.rd_valid); end
    s_if.clr_err = 1'b1;
    tick();
    checks++; if (s_if.data_out !== 8'h66 || s_if.underflow !== 1'b0) begin errors++; $display("FAIL sim_clr_rd: got data=%h udf=%b want 66 0", s_if.data_out, s_if.underflow); end
    tick();
    checks++; if (s_if.underflow !== 1'b1) begin errors++; $display("FAIL clr_vs_new: got %b want 1", s_if.underflow); end
    s_if.rd_en = 1'b0;
    tick();
    s_if.clr_err = 1'b0;
    checks++; if (s_if.underflow !== 1'b0) begin errors++; $display("FAIL clr_udf: got %b want 0", s_if.underflow); end
  endtask

  task automatic test_flush();
    s_if.rd_en = 1'b1;
    tick();
    checks++; if (s_if.underflow !== 1'b1) begin errors++; $display("FAIL fl_udf_set: got %b want 1", s_if.underflow); end
    s_if.rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_if.wr_en = 1'b1; s_if.data_in = 8'(8'h71 + i);
      tick();
    end
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b1;
    tick();
    s_if.flush = 1'b1; s_if.wr_en = 1'b1; s_if.data_in = 8'h99;
    tick();
    s_if.flush = 1'b0; s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
    $display("flush std: count=%0d data=%h", s_if.count, s_if.data_out);
    checks++; if (s_if.count !== 5'd0 || s_if.empty !== 1'b1 || s_if.almost_empty !== 1'b1) begin errors++; $display("FAIL fl_state: got count=%0d empty=%b ae=%b want 0 1 1", s_if.count, s_if.empty, s_if.almost_empty); end
    checks++; if (s_if.rd_valid !== 1'b0 || s_if.data_out !== 8'h71) begin errors++; $display("FAIL fl_out: got valid=%b data=%h want 0 71", s_if.rd_valid, s_if.data_out); end
    checks++; if (s_if.underflow !== 1'b1) begin errors++; $display("FAIL fl_sticky: got %b want 1", s_if.underflow); end
    s_if.wr_en = 1'b1; s_if.data_in = 8'h5A;
    tick();
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b1;
    tick();
    s_if.rd_en = 1'b0; s_if.clr_err = 1'b1;
    checks++; if (s_if.data_out !== 8'h5A || s_if.empty !== 1'b1) begin errors++; $display("FAIL fl_after: got data=%h empty=%b want 5a 1", s_if.data_out, s_if.empty); end
    tick();
    s_if.clr_err = 1'b0;
  endtask

  task automatic test_wrap();
    logic [1:0] pat [8];
    int wr_idx, rd_idx, cnt;
    logic [1:0] p;
    // bit1 = write, bit0 = read; net zero per 8 cycles, count stays 4..7
    pat = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10};
    wr_idx = 0; rd_idx = 0; cnt = 0;
    for (int i = 0; i < 5; i++) begin
      s_if.wr_en = 1'b1; s_if.data_in = 8'(wr_idx * 7 + 3);
      tick();
      wr_idx++; cnt++;
    end
    for (int c = 0; c < 40; c++) begin
      p = pat[c % 8];
      s_if.wr_en = p[1]; s_if.rd_en = p[0]; s_if.data_in = 8'(wr_idx * 7 + 3);
      tick();
      if (p[1]) begin wr_idx++; cnt++; end
      if (p[0]) begin
        $display("wrap: rd %h", s_if.data_out);
        checks++; if (s_if.rd_valid !== 1'b1 || s_if.data_out !== 8'(rd_idx * 7 + 3)) begin errors++; $display("FAIL wrap_data: got valid=%b data=%h want 1 %h", s_if.rd_valid, s_if.data_out, 8'(rd_idx * 7 + 3)); end
        rd_idx++; cnt--;
      end else begin
        checks++; if (s_if.rd_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid: got %b want 0", s_if.rd_valid); end
      end
      checks++; if (s_if.count !== 5'(cnt)) begin errors++; $display("FAIL wrap_count: got %0d want %0d", s_if.count, cnt); end
    end
    s_if.wr_en = 1'b0;
    while (rd_idx < wr_idx) begin
      s_if.rd_en = 1'b1;
      tick();
      checks++; if (s_if.data_out !== 8'(rd_idx * 7 + 3)) begin errors++; $display("FAIL wrap_tail: got %h want %h", s_if.data_out, 8'(rd_idx * 7 + 3)); end
      rd_idx++;
    end
    s_if.rd_en = 1'b0;
    checks++; if (s_if.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", s_if.empty); end
  endtask

  task automatic test_fwft();
    f_if.wr_en = 1'b1; f_if.data_in = 8'h3C;
    tick();
    f_if.wr_en = 1'b0;
    $display("fwft: wr 3c -> data=%h valid=%b", f_if.data_out, f_if.rd_valid);
    checks++; if (f_if.data_out !== 8'h3C || f_if.rd_valid !== 1'b1 || f_if.empty !== 1'b0) begin errors++; $display("FAIL fwft_first: got data=%h valid=%b empty=%b want 3c 1 0", f_if.data_out, f_if.rd_valid, f_if.empty); end
    tick();
    checks++; if (f_if.data_out !== 8'h3C || f_if.count !== 5'd1) begin errors++; $display("FAIL fwft_hold: got data=%h count=%0d want 3c 1", f_if.data_out, f_if.count); end
    for (int i = 0; i < 4; i++) begin
      f_if.wr_en = 1'b1; f_if.data_in = 8'(8'h4D + i * 17);
      tick();
    end
    f_if.wr_en = 1'b0;
    checks++; if (f_if.count !== 5'd5 || f_if.data_out !== 8'h3C) begin errors++; $display("FAIL fwft_fill: got count=%0d data=%h want 5 3c", f_if.count, f_if.data_out); end
    f_if.rd_en = 1'b1;
    tick();
    f_if.rd_en = 1'b0;
    checks++; if (f_if.data_out !== 8'h4D || f_if.count !== 5'd4) begin errors++; $display("FAIL fwft_pop: got data=%h count=%0d want 4d 4", f_if.data_out, f_if.count); end
    f_if.wr_en = 1'b1; f_if.data_in = 8'h81;
    tick();
    f_if.wr_en = 1'b0; f_if.flush = 1'b1;
    checks++; if (f_if.count !== 5'd5) begin errors++; $display("FAIL fwft_pre_flush: got %0d want 5", f_if.count); end
    tick();
    f_if.flush = 1'b0;
    $display("fwft: flush -> count=%0d empty=%b", f_if.count, f_if.empty);
    checks++; if (f_if.empty !== 1'b1 || f_if.count !== 5'd0 || f_if.rd_valid !== 1'b0) begin errors++; $display("FAIL fwft_flush: got empty=%b count=%0d valid=%b want 1 0 0", f_if.empty, f_if.count, f_if.rd_valid); end
    f_if.wr_en = 1'b1; f_if.data_in = 8'h92;
    tick();
    f_if.wr_en = 1'b0;
    checks++; if (f_if.data_out !== 8'h92 || f_if.rd_valid !== 1'b1) begin errors++; $display("FAIL fwft_after_flush: got data=%h valid=%b want 92 1", f_if.data_out, f_if.rd_valid); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_flush();
    test_wrap();
    test_fwft();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached without completion, want finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
